// File: rtl/bus_probe_pkg.sv
// Shared definitions for the bus probe: FSM encodings, monitor control/status
// bit positions and the snapshot frame layout.
package bus_probe_pkg;

  // Bus-cycle tracking states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HOLD = 3'd2,
    ST_ACK  = 3'd3,
    ST_BERR = 3'd4
  } probe_state_t;

  // INPUT_SIGNAL bit positions (shared with the SPI monitor)
  localparam int IN_HALT_EN = 0;
  localparam int IN_STEP    = 1;
  localparam int IN_RSVD    = 2;
  localparam int IN_CPU_RST = 3;

  // OUTPUT_SIGNAL bit positions
  localparam int OUT_RW   = 0;
  localparam int OUT_UDS  = 1;
  localparam int OUT_LDS  = 2;
  localparam int OUT_HELD = 3;

  // Wait-state counter width (covers WAIT_LIMIT up to 255)
  localparam int CNT_W = 8;

  // Snapshot frame handed to the monitor
  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        lds;
    logic        uds;
    logic        rw;
  } snap_t;

endpackage

// File: rtl/bus_probe_signal_sync.sv
// N-bit two-flop synchronizer for the monitor control lines.
module signal_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  // Two-stage capture of the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_probe.sv
// 68000 bus probe: snapshots each bus cycle for the SPI monitor, can hold the
// CPU in a cycle (halt / single-step) and generates DTACK_N / BERR_N.
module bus_probe
  import bus_probe_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic        AS_N_IN,
  input  logic        UDS_N_IN,
  input  logic        LDS_N_IN,
  input  logic        RW_IN,
  input  logic [23:0] ADDR_IN,
  input  logic [15:0] DATA_IN,
  input  logic        DTACK_N_IN,
  input  logic [3:0]  INPUT_SIGNAL_IN,
  output logic [23:0] ADDR,
  output logic [15:0] DATA,
  output logic [3:0]  OUTPUT_SIGNAL,
  output logic        DTACK_N,
  output logic        BERR_N,
  output logic        CPU_RESET
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  probe_state_t     state, state_nxt;
  logic [3:0]       ctl_sync;
  logic             step_prev;
  logic             halt_en, step_pulse;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  snap_t            snap;
  logic             held_q, held_d;
  logic             dtack_n_d, berr_n_d;
  logic             latch_req, latch_data;
  logic             unused_rsvd;

  signal_sync #(.N(4)) u_sync (
    .clk (CLK_IN),
    .rst (RESET_IN),
    .d   (INPUT_SIGNAL_IN),
    .q   (ctl_sync)
  );

  assign halt_en     = ctl_sync[IN_HALT_EN];
  assign step_pulse  = ctl_sync[IN_STEP] & ~step_prev;
  assign unused_rsvd = ctl_sync[IN_RSVD];

  // State register
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state; an aborted cycle (AS_N high) always wins, then DTACK beats the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!AS_N_IN) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (AS_N_IN)               state_nxt = ST_IDLE;
        else if (!DTACK_N_IN)      state_nxt = halt_en ? ST_HOLD : ST_ACK;
        else if (wait_cnt == LIMIT) state_nxt = ST_BERR;
      end
      ST_HOLD: begin
        if (AS_N_IN)                      state_nxt = ST_IDLE;
        else if (step_pulse || !halt_en)  state_nxt = ST_ACK;
      end
      ST_ACK:  if (AS_N_IN) state_nxt = ST_IDLE;
      ST_BERR: if (AS_N_IN) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of registered outputs, snapshot enables and wait counter
  always_comb begin
    dtack_n_d  = (state_nxt != ST_ACK);
    berr_n_d   = (state_nxt != ST_BERR);
    held_d     = held_q;
    if (state_nxt == ST_HOLD)      held_d = 1'b1;
    else if (state_nxt == ST_IDLE) held_d = 1'b0;
    latch_req  = (state == ST_IDLE) && !AS_N_IN;
    latch_data = (state == ST_WAIT) && !AS_N_IN && !DTACK_N_IN;
    wait_cnt_d = wait_cnt;
    if (latch_req)
      wait_cnt_d = '0;
    else if ((state == ST_WAIT) && DTACK_N_IN && (wait_cnt != '1))
      wait_cnt_d = wait_cnt + CNT_W'(1);
  end

  // Output, snapshot and bookkeeping registers
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      snap      <= '0;
      held_q    <= 1'b0;
      DTACK_N   <= 1'b1;
      BERR_N    <= 1'b1;
      CPU_RESET <= 1'b0;
      wait_cnt  <= '0;
      step_prev <= 1'b0;
    end else begin
      if (latch_req) begin
        snap.addr <= ADDR_IN;
        snap.rw   <= RW_IN;
        snap.uds  <= ~UDS_N_IN;
        snap.lds  <= ~LDS_N_IN;
      end
      if (latch_data) snap.data <= DATA_IN;
      held_q    <= held_d;
      DTACK_N   <= dtack_n_d;
      BERR_N    <= berr_n_d;
      CPU_RESET <= ctl_sync[IN_CPU_RST];
      wait_cnt  <= wait_cnt_d;
      step_prev <= ctl_sync[IN_STEP];
    end
  end

  // Frame presented to the monitor
  always_comb begin
    ADDR                    = snap.addr;
    DATA                    = snap.data;
    OUTPUT_SIGNAL           = '0;
    OUTPUT_SIGNAL[OUT_RW]   = snap.rw;
    OUTPUT_SIGNAL[OUT_UDS]  = snap.uds;
    OUTPUT_SIGNAL[OUT_LDS]  = snap.lds;
    OUTPUT_SIGNAL[OUT_HELD] = held_q;
  end

endmodule

// File: tb/tb_bus_probe.sv
// Directed bench for bus_probe with a snapshot scoreboard.
module tb_bus_probe;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic        AS_N_IN, UDS_N_IN, LDS_N_IN, RW_IN, DTACK_N_IN;
  logic [23:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic [3:0]  INPUT_SIGNAL_IN;
  logic [23:0] ADDR;
  logic [15:0] DATA;
  logic [3:0]  OUTPUT_SIGNAL;
  logic        DTACK_N, BERR_N, CPU_RESET;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [3:0]  sig;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_data = 16'h0;

  bus_probe #(.WAIT_LIMIT(8)) dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .AS_N_IN(AS_N_IN), .UDS_N_IN(UDS_N_IN),
    .LDS_N_IN(LDS_N_IN), .RW_IN(RW_IN), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .DTACK_N_IN(DTACK_N_IN), .INPUT_SIGNAL_IN(INPUT_SIGNAL_IN), .ADDR(ADDR), .DATA(DATA),
    .OUTPUT_SIGNAL(OUTPUT_SIGNAL), .DTACK_N(DTACK_N), .BERR_N(BERR_N), .CPU_RESET(CPU_RESET)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic [3:0] v, input int settle);
    INPUT_SIGNAL_IN = v;
    repeat (settle) tick();
  endtask

  // Drive a bus cycle start and record what the frame must show later
  task automatic start_cycle(input logic [23:0] a, input logic rw, input logic uds,
                             input logic lds, input logic [15:0] d,
                             input logic [15:0] exp_d, input logic exp_held);
    exp_t e;
    AS_N_IN = 1'b0; ADDR_IN = a; RW_IN = rw; UDS_N_IN = ~uds; LDS_N_IN = ~lds;
    DATA_IN = d; DTACK_N_IN = 1'b1;
    e.addr = a; e.data = exp_d; e.sig = {exp_held, lds, uds, rw};
    sb.push_back(e);
    tick();
  endtask

  task automatic end_cycle();
    AS_N_IN = 1'b1; UDS_N_IN = 1'b1; LDS_N_IN = 1'b1; DTACK_N_IN = 1'b1;
    tick();
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " addr"}, 32'(ADDR), 32'(e.addr));
      chk({tag, " data"}, 32'(DATA), 32'(e.data));
      chk({tag, " sig"}, 32'(OUTPUT_SIGNAL), 32'(e.sig));
    end
  endtask

  function automatic logic cond(input int which);
    if (which == 0)      return !DTACK_N;
    else if (which == 1) return !BERR_N;
    else                 return CPU_RESET;
  endfunction

  // Count clocks until the selected output event, bounded
  task automatic wait_evt(input string tag, input int which, input int exp_cnt);
    int k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (cond(which)) break;
    end
    chk(tag, 32'(k), 32'(exp_cnt));
  endtask

  task automatic hold_steady(input string tag, input int n);
    logic moved = 1'b0;
    repeat (n) begin
      tick();
      if (!DTACK_N || !OUTPUT_SIGNAL[3]) moved = 1'b1;
    end
    chk(tag, 32'(moved), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_IN = 1'b1; AS_N_IN = 1'b1; UDS_N_IN = 1'b1; LDS_N_IN = 1'b1; RW_IN = 1'b1;
    ADDR_IN = '0; DATA_IN = '0; DTACK_N_IN = 1'b1; INPUT_SIGNAL_IN = 4'b0000;
    repeat (2) tick();
    chk("rst addr", 32'(ADDR), 32'h0);
    chk("rst data", 32'(DATA), 32'h0);
    chk("rst sig", 32'(OUTPUT_SIGNAL), 32'h0);
    chk("rst dtack", 32'(DTACK_N), 32'h1);
    chk("rst berr", 32'(BERR_N), 32'h1);
    chk("rst cpurst", 32'(CPU_RESET), 32'h0);
    RESET_IN = 1'b0;
    tick();

    // 1: plain read, memory acks two clocks after AS_N
    start_cycle(24'h012344, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0);
    tick();
    DTACK_N_IN = 1'b0;
    chk("t1 dtack_before", 32'(DTACK_N), 32'h1);
    wait_evt("t1 dtack_lat", 0, 1);
    sb_check("t1");
    last_data = 16'hBEEF;
    end_cycle();
    chk("t1 dtack_release", 32'(DTACK_N), 32'h1);

    // 2: halted write, upper byte only, released by STEP
    set_ctl(4'b0001, 4);
    start_cycle(24'h000100, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b1);
    DTACK_N_IN = 1'b0;
    tick();
    chk("t2 sig_held", 32'(OUTPUT_SIGNAL), 32'hA);
    hold_steady("t2 hold50", 50);
    INPUT_SIGNAL_IN = 4'b0011;
    wait_evt("t2 step_lat", 0, 3);
    sb_check("t2");
    last_data = 16'h1234;
    end_cycle();
    chk("t2 held_clear", 32'(OUTPUT_SIGNAL), 32'h2);

    // 3: STEP held high releases only one cycle
    set_ctl(4'b0001, 4);
    start_cycle(24'h000200, 1'b1, 1'b1, 1'b1, 16'hA5A5, 16'hA5A5, 1'b1);
    DTACK_N_IN = 1'b0;
    tick();
    INPUT_SIGNAL_IN = 4'b0011;
    wait_evt("t3a step_lat", 0, 3);
    sb_check("t3a");
    end_cycle();
    start_cycle(24'h000204, 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'h5A5A, 1'b1);
    DTACK_N_IN = 1'b0;
    tick();
    hold_steady("t3b step_level", 10);
    INPUT_SIGNAL_IN = 4'b0001;
    hold_steady("t3b step_fall", 4);
    INPUT_SIGNAL_IN = 4'b0011;
    wait_evt("t3b step_lat", 0, 3);
    sb_check("t3b");
    last_data = 16'h5A5A;
    end_cycle();

    // 4: no acknowledge -> bus error after the wait limit
    set_ctl(4'b0000, 4);
    start_cycle(24'h000300, 1'b1, 1'b1, 1'b1, 16'hDEAD, last_data, 1'b0);
    wait_evt("t4 berr_lat", 1, 9);
    chk("t4 no_dtack", 32'(DTACK_N), 32'h1);
    sb_check("t4");
    end_cycle();
    chk("t4 berr_release", 32'(BERR_N), 32'h1);

    // 5a: dropping HALT_EN releases the held cycle
    set_ctl(4'b0001, 4);
    start_cycle(24'h000400, 1'b0, 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 1'b1);
    DTACK_N_IN = 1'b0;
    tick();
    chk("t5a held", 32'(OUTPUT_SIGNAL[3]), 32'h1);
    INPUT_SIGNAL_IN = 4'b0000;
    wait_evt("t5a halt_drop", 0, 3);
    sb_check("t5a");
    last_data = 16'h0F0F;
    end_cycle();

    // 5b: asynchronous reset while held
    set_ctl(4'b0001, 4);
    start_cycle(24'h000500, 1'b1, 1'b0, 1'b1, 16'h7777, 16'h7777, 1'b1);
    DTACK_N_IN = 1'b0;
    tick();
    sb_check("t5b hold");
    #2;
    RESET_IN = 1'b1;
    #1;
    chk("t5b rst addr", 32'(ADDR), 32'h0);
    chk("t5b rst data", 32'(DATA), 32'h0);
    chk("t5b rst sig", 32'(OUTPUT_SIGNAL), 32'h0);
    chk("t5b rst dtack", 32'(DTACK_N), 32'h1);
    chk("t5b rst berr", 32'(BERR_N), 32'h1);
    AS_N_IN = 1'b1; UDS_N_IN = 1'b1; LDS_N_IN = 1'b1; DTACK_N_IN = 1'b1;
    tick();
    RESET_IN = 1'b0;
    last_data = 16'h0;
    set_ctl(4'b0000, 4);

    // 6a: CPU reset request
    INPUT_SIGNAL_IN = 4'b1000;
    wait_evt("t6 cpurst_lat", 2, 3);
    set_ctl(4'b0000, 4);
    chk("t6 cpurst_off", 32'(CPU_RESET), 32'h0);

    // 6b: cycle aborted in WAIT, then a normal cycle proves we are back in IDLE
    start_cycle(24'h000600, 1'b1, 1'b1, 1'b1, 16'h1111, last_data, 1'b0);
    tick();
    AS_N_IN = 1'b1;
    tick();
    chk("t6 abort dtack", 32'(DTACK_N), 32'h1);
    sb_check("t6 abort");
    start_cycle(24'h000700, 1'b1, 1'b0, 1'b1, 16'h2222, 16'h2222, 1'b0);
    DTACK_N_IN = 1'b0;
    wait_evt("t6 next_lat", 0, 1);
    sb_check("t6 next");
    end_cycle();

    // 6c: cycle aborted in HOLD clears HELD
    set_ctl(4'b0001, 4);
    start_cycle(24'h000800, 1'b1, 1'b1, 1'b1, 16'h3333, 16'h3333, 1'b0);
    DTACK_N_IN = 1'b0;
    tick();
    chk("t6c held", 32'(OUTPUT_SIGNAL[3]), 32'h1);
    AS_N_IN = 1'b1; DTACK_N_IN = 1'b1;
    tick();
    chk("t6c dtack", 32'(DTACK_N), 32'h1);
    sb_check("t6c abort");

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
